// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle 16-bit core:
// opcodes, ALU operation codes, FSM states and decode helpers.
package core_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;
  localparam logic [3:0] OP_J   = 4'hF;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    return is_rtype(op) ||
           (op inside {OP_LW, OP_SW, OP_BNE, OP_J});
  endfunction

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_SUB:  sel = ALU_SUB;
      OP_SLT:  sel = ALU_SLT;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: and/or/add/sub/slt with signed overflow
// flag for add and sub.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam int MSB = DATA_W - 1;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = a + b;
        ovf = (a[MSB] == b[MSB]) &&
              (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf = (a[MSB] != b[MSB]) &&
              (result[MSB] != a[MSB]);
      end
      ALU_SLT: begin
        result = {{(DATA_W-1){1'b0}},
                  ($signed(a) < $signed(b))};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit ISA core sharing one req/ack memory port
// between instruction fetch and data access.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted,
  output logic              ovf
);

  state_t state, state_n;

  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr;
  logic [DATA_W-1:0] ra, rb;
  logic [ADDR_W-1:0] pc, pc_inc, pc_n;

  logic [3:0]        op, dst, rs, rb_idx;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  logic              is_r, is_mem, bus_done, complete;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_ovf;

  assign op     = ir[15:12];
  assign dst    = ir[11:8];
  assign rs     = ir[7:4];
  assign is_r   = is_rtype(op);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign rb_idx = is_r ? ir[3:0] : ir[11:8];
  assign imm_d  = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign imm_a  = {{(ADDR_W-4){ir[3]}}, ir[3:0]};
  assign pc_inc = pc + ADDR_W'(1);

  // Only an acknowledged cycle of an issued request counts.
  assign bus_done = mem_req && mem_ack;

  assign ra = (rs == 4'd0) ? '0 : regs[rs];
  assign rb = (rb_idx == 4'd0) ? '0 : regs[rb_idx];

  assign alu_op = is_mem ? ALU_ADD : alu_sel(op);
  assign alu_b  = is_mem ? imm_d : b_q;

  core_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .alu_op(alu_op),
    .a     (a_q),
    .b     (alu_b),
    .result(alu_res),
    .ovf   (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    complete = 1'b0;
    unique case (state)
      FETCH: if (bus_done) state_n = DECODE;
      DECODE: state_n = op_valid(op) ? EXEC : HALT;
      EXEC: begin
        unique case (1'b1)
          is_r:   state_n = WB;
          is_mem: state_n = MEM;
          (op == OP_BNE): begin
            pc_n = (a_q != b_q) ? pc_inc + imm_a
                                : pc_inc;
            complete = 1'b1;
            state_n  = FETCH;
          end
          (op == OP_J): begin
            pc_n = {pc_inc[ADDR_W-1:12], ir[11:0]};
            complete = 1'b1;
            state_n  = FETCH;
          end
          default: state_n = HALT;
        endcase
      end
      MEM: begin
        if (bus_done) begin
          if (op == OP_SW) begin
            pc_n     = pc_inc;
            complete = 1'b1;
            state_n  = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        pc_n     = pc_inc;
        complete = 1'b1;
        state_n  = FETCH;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  assign retire = complete && !reset;
  assign pc_out = pc;

  // Bus outputs are registered from the next state so a request
  // is already on the port in the first cycle of FETCH/MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr       <= '0;
      ovf       <= 1'b0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      pc      <= pc_n;
      halted  <= (state_n == HALT);
      mem_req <= (state_n == FETCH) || (state_n == MEM);
      mem_we  <= (state_n == MEM) && (op == OP_SW);
      if (state_n == FETCH) begin
        mem_addr <= pc_n;
      end else if (state == EXEC && state_n == MEM) begin
        mem_addr  <= ADDR_W'(alu_res);
        mem_wdata <= b_q;
      end
      if (state == FETCH && bus_done) ir <= mem_rdata[15:0];
      if (state == DECODE) begin
        a_q <= ra;
        b_q <= rb;
      end
      if (state == EXEC) begin
        alu_q <= alu_res;
        if ((op == OP_ADD || op == OP_SUB) && alu_ovf)
          ovf <= 1'b1;
      end
      if (state == MEM && bus_done) mdr <= mem_rdata;
      if (state == WB && dst != 4'd0)
        regs[dst] <= (op == OP_LW) ? mdr : alu_q;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: bus-access scoreboard plus
// latency, flag and reset checks.
module tb_multicycle_core;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        retire, halted, ovf;

  logic [15:0] mem [65536];
  acc_t        q [$];
  int          stamps [$];
  acc_t        got, want;
  int nvec = 0, nerr = 0;
  int cyc = 0, rcount = 0, wecyc = 0;
  int rwait = 0, wwait = 0, wcnt = 0;

  multicycle_core #(
    .DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_out(pc_out), .retire(retire),
    .halted(halted), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack = mem_req &&
    (wcnt >= (mem_we ? wwait : rwait));

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Bus monitor: every completed access is popped and compared.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (retire) begin
        rcount++;
        stamps.push_back(cyc);
      end
      if (mem_we) wecyc++;
      if (mem_req && mem_ack) begin
        got = {mem_addr, mem_we, mem_we ? mem_wdata : 16'h0};
        if (mem_we) mem[mem_addr] = mem_wdata;
        want = (q.size() > 0) ? q.pop_front() : ~got;
        nvec++;
        assert (got === want) else begin
          nerr++;
          $error("FAIL bus: observed %h expected %h", got, want);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a);
    q.push_back({a, 1'b0, 16'h0});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    q.push_back({a, 1'b1, d});
  endtask

  task automatic rst_begin(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_pc"}, 32'(pc_out), 0);
    chk({tag, "_halt"}, 32'(halted), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_ret"}, 32'(retire), 0);
    for (int i = 0; i < 65536; i++) mem[i] = 16'h3000;
    q.delete();
    stamps.delete();
    rcount = 0;
    wecyc = 0;
    rwait = 0;
    wwait = 0;
  endtask

  task automatic rst_end();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ret(input int n, input string tag);
    int k = 0;
    while (rcount < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(rcount >= n), 1);
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(halted), 1);
  endtask

  initial begin
    int k;
    logic quiet;

    // Scenario 1: loads, ALU ops, R0 rule, overflow, slt.
    rst_begin("rst1");
    mem[16'hFFFE] = 16'h0005; mem[16'hFFFF] = 16'h0007;
    mem[16'hFFFB] = 16'h8000; mem[16'hFFFA] = 16'h0001;
    mem[16'hFFF8] = 16'hFFFF;
    mem[0]  = 16'h810E; mem[1]  = 16'h820F; mem[2]  = 16'h2312;
    mem[3]  = 16'hA30D; mem[4]  = 16'h2012; mem[5]  = 16'h2500;
    mem[6]  = 16'hA50C; mem[7]  = 16'h860B; mem[8]  = 16'h870A;
    mem[9]  = 16'h6867; mem[10] = 16'hA809; mem[11] = 16'h8908;
    mem[12] = 16'h7497; mem[13] = 16'hA460; mem[14] = 16'h7A79;
    mem[15] = 16'hAA61; mem[16] = 16'h0B69; mem[17] = 16'h1C12;
    mem[18] = 16'hAB62; mem[19] = 16'hAC63;
    rd(0); rd(16'hFFFE); rd(1); rd(16'hFFFF); rd(2); rd(3);
    wr(16'hFFFD, 12); rd(4); rd(5); rd(6); wr(16'hFFFC, 0);
    rd(7); rd(16'hFFFB); rd(8); rd(16'hFFFA); rd(9); rd(10);
    wr(16'hFFF9, 16'h7FFF); rd(11); rd(16'hFFF8); rd(12); rd(13);
    wr(16'h8000, 1); rd(14); rd(15); wr(16'h8001, 0);
    rd(16); rd(17); rd(18); wr(16'h8002, 16'h8000);
    rd(19); wr(16'h8003, 7); rd(20);
    rst_end();
    wait_ret(3, "s1_ret3");
    chk("s1_ovf_add", 32'(ovf), 0);
    chk("s1_lat_lw", 32'(stamps[1] - stamps[0]), 5);
    chk("s1_lat_add", 32'(stamps[2] - stamps[1]), 4);
    wait_ret(9, "s1_ret9");
    chk("s1_ovf_pre", 32'(ovf), 0);
    chk("s1_lat_sw", 32'(stamps[3] - stamps[2]), 4);
    wait_ret(10, "s1_ret10");
    chk("s1_ovf_sub", 32'(ovf), 1);
    chk("s1_lat_sub", 32'(stamps[9] - stamps[8]), 4);
    wait_halt("s1_halt");
    chk("s1_ovf_sticky", 32'(ovf), 1);
    chk("s1_pc", 32'(pc_out), 20);
    chk("s1_retires", 32'(rcount), 20);
    chk("s1_sb_empty", 32'(q.size()), 0);

    // Scenario 2: bne both ways, j across 4K pages, slow store.
    rst_begin("rst2");
    mem[16'hFFFE] = 16'h0005; mem[16'hFFFF] = 16'h0007;
    mem[16'hFFFD] = 16'h000C; mem[16'hFFFC] = 16'h0020;
    mem[0] = 16'h810E; mem[1] = 16'h820F; mem[2] = 16'hF00A;
    mem[9] = 16'h820E; mem[10] = 16'hE12E; mem[11] = 16'hFFFF;
    mem[16'h0FFF] = 16'hFFFF; mem[16'h1FFF] = 16'hF005;
    mem[16'h2005] = 16'hF123; mem[16'h2123] = 16'h830D;
    mem[16'h2124] = 16'h840C; mem[16'h2125] = 16'hA340;
    rd(0); rd(16'hFFFE); rd(1); rd(16'hFFFF); rd(2); rd(10);
    rd(9); rd(16'hFFFE); rd(10); rd(11); rd(16'h0FFF);
    rd(16'h1FFF); rd(16'h2005); rd(16'h2123); rd(16'hFFFD);
    rd(16'h2124); rd(16'hFFFC); rd(16'h2125); wr(16'h0020, 12);
    rd(16'h2126);
    wwait = 3;
    rst_end();
    wait_halt("s2_halt");
    chk("s2_lat_bne_t", 32'(stamps[3] - stamps[2]), 3);
    chk("s2_lat_bne_nt", 32'(stamps[5] - stamps[4]), 3);
    chk("s2_lat_j", 32'(stamps[6] - stamps[5]), 3);
    chk("s2_lat_sw_wait", 32'(stamps[12] - stamps[11]), 7);
    chk("s2_we_cycles", 32'(wecyc), 4);
    chk("s2_retires", 32'(rcount), 13);
    chk("s2_pc", 32'(pc_out), 32'h2126);
    chk("s2_sb_empty", 32'(q.size()), 0);

    // Scenario 3: invalid opcode at PC 4.
    rst_begin("rst3");
    mem[16'hFFFE] = 16'h0005; mem[16'hFFFF] = 16'h0007;
    mem[0] = 16'h810E; mem[1] = 16'h820F; mem[2] = 16'h2312;
    mem[3] = 16'h1412; mem[4] = 16'h3ABC;
    rd(0); rd(16'hFFFE); rd(1); rd(16'hFFFF); rd(2); rd(3); rd(4);
    rst_end();
    k = 0;
    while (!(mem_req && mem_ack && !mem_we && mem_addr == 16'h4)
           && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("s3_fetch4", 32'(k < 2000), 1);
    @(negedge clk);
    chk("s3_halt_early", 32'(halted), 0);
    @(negedge clk);
    chk("s3_halt", 32'(halted), 1);
    chk("s3_pc", 32'(pc_out), 4);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) quiet = 1'b0;
    end
    chk("s3_no_req", 32'(quiet), 1);
    chk("s3_sb_empty", 32'(q.size()), 0);

    // Scenario 4: reset while a fetch is stalled.
    rst_begin("rst4");
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    rd(0);
    rst_end();
    k = 0;
    while (!retire && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("s4_retire", 32'(retire), 1);
    rwait = 100;
    repeat (3) @(negedge clk);
    chk("s4_stall_req", 32'(mem_req), 1);
    chk("s4_stall_addr", 32'(mem_addr), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("s4_req_drop", 32'(mem_req), 0);
    chk("s4_pc_reset", 32'(pc_out), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("s4_restart_req", 32'(mem_req), 1);
    chk("s4_restart_addr", 32'(mem_addr), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("s4_sb_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
